// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states,
// owner encoding, line-alignment mask helper and default geometry.
// Latency: n/a (declarations only). Backpressure: n/a.
package mem_arb_pkg;

  localparam int unsigned DEF_MEM_LAT    = 4;
  localparam int unsigned DEF_LINE_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Mask that clears the byte-offset-within-line bits of an address.
  function automatic logic [31:0] line_mask(input int unsigned line_words);
    return ~((32'(line_words) << 2) - 32'd1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side (I/D line fill) and memory-side signals.
// Latency: n/a (wiring only). Backpressure: requesters hold *_req until *_ack.
// Modports: slave = arbiter view, master = requesters + memory view.
interface mem_port_arbiter_if #(
  parameter int unsigned LINE_WORDS = 4
);
  localparam int unsigned BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  logic          ic_req;
  logic [31:0]   ic_addr;
  logic          ic_rvalid;
  logic          ic_ack;
  logic          dc_req;
  logic          dc_we;
  logic [31:0]   dc_addr;
  logic [31:0]   dc_wdata;
  logic          dc_rvalid;
  logic          dc_ack;
  logic [31:0]   rdata;
  logic [BW-1:0] beat_idx;
  logic          busy;
  logic          mem_en;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
    output ic_rvalid, ic_ack, dc_rvalid, dc_ack, rdata, beat_idx, busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
    input  ic_rvalid, ic_ack, dc_rvalid, dc_ack, rdata, beat_idx, busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between I-side and D-side line requests.
// Latency: 0 cycles. Backpressure: none; the parent only samples it in IDLE.
// Ports: ic_req/dc_req in, last_grant in (owner of previous grant), grant_vld/grant_own out.
// Build option MEM_ARB_ROUND_ROBIN_EN: defined = round-robin on ties, undefined = D side has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   ic_req,
  input  logic   dc_req,
  input  owner_t last_grant,
  output logic   grant_vld,
  output owner_t grant_own
);

  assign grant_vld = ic_req | dc_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // A lone requester always wins; on a tie the side not granted last wins.
  always_comb begin
    grant_own = dc_req ? OWN_D : OWN_I;
    if (ic_req && dc_req) begin
      grant_own = (last_grant == OWN_D) ? OWN_I : OWN_D;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = (last_grant == OWN_D);
  assign grant_own = dc_req ? OWN_D : OWN_I;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port main memory between I-side and D-side line transfers, one beat at a time.
// Latency: grant in IDLE at T -> mem_en at T+1, beat k rvalid at T+1+(k+1)*MEM_LAT, ack at T+1+LINE_WORDS*MEM_LAT.
// Backpressure: one transfer at a time; requesters stall by holding *_req until their one-cycle *_ack.
// Ports: clock, reset (async active-low), bus (mem_port_arbiter_if.slave: requester and memory signals).
// Tie policy selected by MEM_ARB_ROUND_ROBIN_EN inside mem_arb_pick.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic clock,
  input  logic reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned   BW        = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int unsigned   CW        = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [CW-1:0] LAT_LOAD  = CW'(MEM_LAT - 1);
  localparam logic [31:0]   MASK      = line_mask(LINE_WORDS);

  state_t        state_q, state_d;
  owner_t        owner_q;
  owner_t        last_grant_q;
  logic          we_q;
  logic [31:0]   base_q;
  logic [BW-1:0] beat_q;
  logic [CW-1:0] lat_q;
  logic          ic_rvalid_q, dc_rvalid_q;
  logic [31:0]   rdata_q;

  logic          grant_vld;
  owner_t        grant_own;
  logic          beat_end;
  logic          last_beat;

  mem_arb_pick u_pick (
    .ic_req     (bus.ic_req),
    .dc_req     (bus.dc_req),
    .last_grant (last_grant_q),
    .grant_vld  (grant_vld),
    .grant_own  (grant_own)
  );

  assign beat_end  = (lat_q == '0);
  assign last_beat = (beat_q == LAST_BEAT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.ic_ack    = 1'b0;
    bus.dc_ack    = 1'b0;
    unique case (state_q)
      IDLE: if (grant_vld) state_d = BEAT;
      BEAT: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = we_q;
        // base_q has its offset bits cleared, so OR-ing the beat offset cannot carry.
        bus.mem_addr  = base_q | (32'(beat_q) << 2);
        bus.mem_wdata = we_q ? bus.dc_wdata : '0;
        if (beat_end && last_beat) state_d = DONE;
      end
      DONE: begin
        bus.ic_ack = (owner_q == OWN_I);
        bus.dc_ack = (owner_q == OWN_D);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_q      <= OWN_I;
      last_grant_q <= OWN_I;
      we_q         <= 1'b0;
      base_q       <= '0;
      beat_q       <= '0;
      lat_q        <= '0;
      ic_rvalid_q  <= 1'b0;
      dc_rvalid_q  <= 1'b0;
      rdata_q      <= '0;
    end else begin
      ic_rvalid_q <= 1'b0;
      dc_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            owner_q      <= grant_own;
            last_grant_q <= grant_own;
            we_q         <= (grant_own == OWN_D) && bus.dc_we;
            base_q       <= ((grant_own == OWN_D) ? bus.dc_addr : bus.ic_addr) & MASK;
            beat_q       <= '0;
            lat_q        <= LAT_LOAD;
          end
        end
        BEAT: begin
          if (beat_end) begin
            // Memory data is only valid in the last cycle of the beat.
            if (!we_q) begin
              rdata_q     <= bus.mem_rdata;
              ic_rvalid_q <= (owner_q == OWN_I);
              dc_rvalid_q <= (owner_q == OWN_D);
            end
            if (!last_beat) begin
              beat_q <= beat_q + BW'(1);
              lat_q  <= LAT_LOAD;
            end
          end else begin
            lat_q <= lat_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ic_rvalid = ic_rvalid_q;
  assign bus.dc_rvalid = dc_rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.beat_idx  = beat_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed and random line transfers checked each cycle against a timing model.
// Latency: n/a. Backpressure: requesters hold req until ack and drop it the cycle after.
// Honours MEM_ARB_ROUND_ROBIN_EN for the expected tie winner.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int L    = 4;
  localparam int N    = 4;
  localparam int XFER = N * L;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.LINE_WORDS(N)) bus ();
  mem_port_arbiter_if #(.LINE_WORDS(1)) bus1 ();

  mem_port_arbiter #(.MEM_LAT(L), .LINE_WORDS(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  mem_port_arbiter #(.MEM_LAT(1), .LINE_WORDS(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  // reference model of the current transfer
  bit          act    = 1'b0;
  int          t0     = 0;
  owner_t      m_own  = OWN_I;
  owner_t      m_last = OWN_I;
  logic [31:0] m_base = '0;
  bit          m_we   = 1'b0;
  logic [31:0] m_wbase = '0;
  // requester state
  logic [31:0] wbase = '0;
  int          mode  = 0;   // 0 directed, 1 eager (re-request asap), 2 random
  bit          ic_hold = 1'b0, dc_hold = 1'b0;
  bit          ack_i = 1'b0, ack_d = 1'b0;

  function automatic logic [31:0] mf(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5AC3_3CA5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, 32'({bus.mem_en, bus.mem_we, bus.busy, bus.ic_rvalid,
                             bus.dc_rvalid, bus.ic_ack, bus.dc_ack}), 32'd0);
    chk({tag, "_addr"},  bus.mem_addr, 32'd0);
    chk({tag, "_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_rdata"}, bus.rdata, 32'd0);
    chk({tag, "_beat"},  32'(bus.beat_idx), 32'd0);
  endtask

  // One clock cycle: model + drive at negedge, compare, then requester actions after posedge.
  task automatic step();
    int d, k, e_bi;
    bit e_en, e_we, e_busy, e_irv, e_drv, e_iack, e_dack;
    logic [31:0] e_addr, e_wd, e_rd;
    @(negedge clock);
    if (act && (cyc - t0) >= XFER + 2) act = 1'b0;
    if (!act && (bus.ic_req || bus.dc_req)) begin
      if (bus.ic_req && bus.dc_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        m_own = (m_last == OWN_D) ? OWN_I : OWN_D;
`else
        m_own = OWN_D;
`endif
      end else begin
        m_own = bus.dc_req ? OWN_D : OWN_I;
      end
      m_last  = m_own;
      act     = 1'b1;
      t0      = cyc;
      m_base  = (((m_own == OWN_D) ? bus.dc_addr : bus.ic_addr) / 32'(N * 4)) * 32'(N * 4);
      m_we    = (m_own == OWN_D) && bus.dc_we;
      m_wbase = wbase;
    end
    d = act ? cyc - t0 : 0;
    e_en = 0; e_we = 0; e_irv = 0; e_drv = 0; e_iack = 0; e_dack = 0;
    e_addr = '0; e_wd = '0; e_rd = '0; e_bi = 0;
    if (act && d >= 1 && d <= XFER) begin
      k      = (d - 1) / L;
      e_en   = 1'b1;
      e_we   = m_we;
      e_addr = m_base + 32'(4 * k);
      e_wd   = m_we ? m_wbase + 32'(k) : 32'd0;
      e_bi   = k;
    end
    if (act && !m_we && d > L && d <= XFER + 1 && (d - 1) % L == 0) begin
      if (m_own == OWN_I) e_irv = 1'b1; else e_drv = 1'b1;
      e_rd = mf(m_base + 32'(4 * ((d - 1) / L - 1)));
    end
    if (act && d == XFER + 1) begin
      if (m_own == OWN_I) e_iack = 1'b1; else e_dack = 1'b1;
    end
    e_busy = act && d >= 1 && d <= XFER + 1;
    bus.dc_wdata  = wbase + 32'(bus.beat_idx);
    bus.mem_rdata = (e_en && (d % L) == 0) ? mf(e_addr) : $urandom();
    #1;
    chk("ctrl", 32'({bus.mem_en, bus.mem_we, bus.busy, bus.ic_rvalid, bus.dc_rvalid, bus.ic_ack, bus.dc_ack}),
                32'({e_en, e_we, e_busy, e_irv, e_drv, e_iack, e_dack}));
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("mem_wdata", bus.mem_wdata, e_wd);
    if (e_irv || e_drv) chk("rdata", bus.rdata, e_rd);
    if (e_en) chk("beat_idx", 32'(bus.beat_idx), 32'(e_bi));
    ack_i = e_iack;
    ack_d = e_dack;
    @(posedge clock);
    cyc++;
    #1;
    ic_hold = ack_i;
    dc_hold = ack_d;
    if (ack_i) bus.ic_req = 1'b0;
    if (ack_d) bus.dc_req = 1'b0;
    if (mode != 0) begin
      if (!bus.ic_req && !ic_hold && (mode == 1 || $urandom_range(0, 9) == 0)) begin
        bus.ic_req  = 1'b1;
        bus.ic_addr = $urandom();
      end
      if (!bus.dc_req && !dc_hold && (mode == 1 || $urandom_range(0, 9) == 0)) begin
        bus.dc_req  = 1'b1;
        bus.dc_addr = $urandom();
        bus.dc_we   = 1'($urandom_range(0, 1));
        wbase       = $urandom();
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus.ic_req = 0; bus.ic_addr = '0; bus.dc_req = 0; bus.dc_we = 0;
    bus.dc_addr = '0; bus.dc_wdata = '0; bus.mem_rdata = '0;
    bus1.ic_req = 0; bus1.ic_addr = '0; bus1.dc_req = 0; bus1.dc_we = 0;
    bus1.dc_addr = '0; bus1.dc_wdata = '0; bus1.mem_rdata = '0;

    // reset state
    #2;
    chk_zero("reset");
    chk("reset_dut1", 32'({bus1.mem_en, bus1.busy, bus1.ic_ack, bus1.ic_rvalid}), 32'd0);
    @(posedge clock); #2 reset = 1'b1;
    @(posedge clock); #1;
    run(2);

    // I read alone from a misaligned address
    bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_1004;
    run(XFER + 4);

    // D line write with wdata 0xA0 + beat
    bus.dc_req = 1'b1; bus.dc_addr = 32'h0000_2000; bus.dc_we = 1'b1; wbase = 32'hA0;
    run(XFER + 4);

    // tie from IDLE, then D alone followed by another tie
    bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_4010;
    bus.dc_req = 1'b1; bus.dc_addr = 32'h0000_5020; bus.dc_we = 1'b0;
    run(2 * XFER + 8);
    bus.dc_req = 1'b1; bus.dc_addr = 32'h0000_6000; bus.dc_we = 1'b0;
    run(XFER + 4);
    bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_7000;
    bus.dc_req = 1'b1; bus.dc_addr = 32'hFFFF_FFFC; bus.dc_we = 1'b1; wbase = 32'h1234_0000;
    run(2 * XFER + 8);

    // both requesters re-request as early as allowed
    mode = 1;
    run(6 * (XFER + 2));
    mode = 0;
    run(2 * (XFER + 2) + 4);

    // reset in the middle of an I read aborts it without ack
    bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_1004;
    run(7);
    #1 reset = 1'b0;
    #1 chk_zero("mid_reset");
    bus.ic_req = 1'b0;
    act = 1'b0; m_last = OWN_I; ic_hold = 0; dc_hold = 0; ack_i = 0; ack_d = 0;
    @(negedge clock); #2 reset = 1'b1;
    @(posedge clock); #1;
    run(3);
    bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_1004;
    run(XFER + 4);

    // random traffic
    mode = 2;
    run(1500);
    mode = 0;
    run(2 * (XFER + 2) + 4);

    // MEM_LAT=1, LINE_WORDS=1 read
    bus1.ic_req = 1'b1; bus1.ic_addr = 32'h0000_3006;
    @(negedge clock);
    chk("l1_t0_en", 32'(bus1.mem_en), 32'd0);
    @(posedge clock); #1;
    bus1.mem_rdata = mf(32'h0000_3004);
    @(negedge clock);
    chk("l1_t1_ctrl", 32'({bus1.mem_en, bus1.busy, bus1.ic_rvalid, bus1.ic_ack}), 32'b1100);
    chk("l1_t1_addr", bus1.mem_addr, 32'h0000_3004);
    @(posedge clock); #1;
    bus1.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("l1_t2_ctrl", 32'({bus1.mem_en, bus1.busy, bus1.ic_rvalid, bus1.ic_ack}), 32'b0111);
    chk("l1_t2_rdata", bus1.rdata, mf(32'h0000_3004));
    @(posedge clock); #1;
    bus1.ic_req = 1'b0;
    @(negedge clock);
    chk("l1_t3_ctrl", 32'({bus1.mem_en, bus1.busy, bus1.ic_rvalid, bus1.ic_ack}), 32'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
